debug_burst_master: RTL and testbench
=====================================

DEBUG_BURST_MASTER -- requirements
Module: debug_burst_master

Interface
REQ-001 SHALL have parameter ADDR_BYTES, default 2: address bytes per command, MSB first, range 1..4.
REQ-002 SHALL have parameter DATA_BYTES, default 1: bytes per bus word, MSB first, range 1..4.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum wait in cycles for bus ready/valid, range 1..65535.
REQ-004 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_com_data  in  8  received host byte.
REQ-007 SHALL have port i_com_strobe  in  1  i_com_data valid for this cycle.
REQ-008 SHALL have port i_com_tx_ready  in  1  transmitter can accept a byte this cycle.
REQ-009 SHALL have port o_com_data  out  8  response byte.
REQ-010 SHALL have port o_com_strobe  out  1  one-cycle pulse; o_com_data valid.
REQ-011 SHALL have port o_bus_addr  out  8*ADDR_BYTES  bus address.
REQ-012 SHALL have port o_bus_write_data  out  8*DATA_BYTES  bus write word.
REQ-013 SHALL have port o_bus_write_enable  out  1  write request, held until i_bus_ready or timeout.
REQ-014 SHALL have port o_bus_read_enable  out  1  read request, held until i_bus_read_data_valid or timeout.
REQ-015 SHALL have port i_bus_ready  in  1  write accepted this cycle.
REQ-016 SHALL have port i_bus_read_data  in  8*DATA_BYTES  read word.
REQ-017 SHALL have port i_bus_read_data_valid  in  1  i_bus_read_data valid this cycle.

Function
REQ-018 Commands in IDLE: "W" addr data -> single write; "R" addr -> single read; "B" n addr data*(n+1) -> burst write; "C" n addr -> burst read; n is one byte, n+1 words, 1..256.
REQ-019 Any other byte in IDLE SHALL trigger a "?" response; no bus access.
REQ-020 States: IDLE, COUNT, ADDR, DATA, WRITE, READ, TX; ADDR and DATA each consume exactly ADDR_BYTES / DATA_BYTES strobed bytes via a byte counter.
REQ-021 Address and data bytes SHALL shift in MSB first; o_bus_addr updated only after the last address byte.
REQ-022 WRITE entered the cycle after the last data byte; o_bus_write_enable high from that cycle until the cycle i_bus_ready is sampled high, inclusive.
REQ-023 READ entered the cycle after the last address byte; o_bus_read_enable high until i_bus_read_data_valid, inclusive; word latched that cycle.
REQ-024 After each completed word of B/C: o_bus_addr increments by 1, modulo 2^(8*ADDR_BYTES); remaining count decrements; wrap from all-ones to 0 is legal.
REQ-025 Burst write: after each WRITE, return to DATA if words remain, else TX with "K".
REQ-026 Read response: DATA_BYTES bytes MSB first per word; burst read re-enters READ after last byte of each word until count exhausted; no trailing "K".
REQ-027 TX: each byte driven with o_com_strobe for exactly one cycle, only in a cycle where i_com_tx_ready=1; otherwise held pending.
REQ-028 Timeout: counter cleared on WRITE/READ entry, +1 per waiting cycle; reaching TIMEOUT_CYCLES drops the enable, abandons the command and remaining burst, sends "E", returns to IDLE.
REQ-029 i_bus_ready/valid in the same cycle the counter hits TIMEOUT_CYCLES SHALL count as success, not timeout.
REQ-030 i_com_strobe in WRITE, READ or TX SHALL be ignored; host waits for the response.
REQ-031 i_bus_ready outside WRITE and i_bus_read_data_valid outside READ SHALL be ignored.
REQ-032 After "E" during burst write, leftover host bytes are parsed as commands from IDLE; host resync is host responsibility.

Reset
REQ-033 rst=1 SHALL force IDLE, all outputs 0, counters and address 0 on the next edge, also mid-command, aborting any bus access without response.
REQ-034 rst SHALL take priority over all other inputs in the same cycle.

Verification
REQ-035 "W",0x12,0x34,0xA5; ready after 3 cycles -> one write addr 0x1234 data 0xA5, enable high 4 cycles, then "K".
REQ-036 "R",0x00,0x10; valid with 0x5C after 2 cycles -> enable high 3 cycles, one byte 0x5C.
REQ-037 "B",0x02,0xFF,0xFE, 0x01,0x02,0x03 -> writes to 0xFFFE,0xFFFF,0x0000 (wrap), single "K" at end.
REQ-038 "C",0x01,0x20,0x00 with DATA_BYTES=2, words 0xBEEF,0xCAFE -> bytes BE,EF,CA,FE; tx_ready low 5 cycles mid-stream delays but drops nothing.
REQ-039 "R",0x00,0x00, no valid, TIMEOUT_CYCLES=8 -> enable drops after 8 cycles, "E"; next "W" works; unknown 0x41 -> "?".
REQ-040 rst asserted during burst-write DATA phase -> IDLE, all outputs 0, no "K"; next command works normally.

Source files
------------

// File: rtl/debug_burst_master.sv
// debug_burst_master
//   Lets a byte-oriented host link (e.g. a UART) drive a simple memory-mapped
//   bus. The host sends single-letter commands followed by a big-endian
//   address and data:
//     "W" addr data          single write, answered with "K"
//     "R" addr               single read, answered with the word's bytes
//     "B" n addr data*(n+1)  burst write of n+1 words, one "K" at the end
//     "C" n addr             burst read of n+1 words, each word's bytes returned
//   Any other byte in IDLE is answered with "?". A bus access that gets no
//   ready/valid within TIMEOUT_CYCLES is abandoned and answered with "E".
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   i_com_data/i_com_strobe  received host byte and its one-cycle valid
//   i_com_tx_ready           transmitter can take a byte this cycle
//   o_com_data/o_com_strobe  response byte and its one-cycle valid
//   o_bus_addr               bus address (8*ADDR_BYTES)
//   o_bus_write_data         bus write word (8*DATA_BYTES)
//   o_bus_write_enable       write request, held until i_bus_ready or timeout
//   o_bus_read_enable        read request, held until valid or timeout
//   i_bus_ready              write accepted this cycle
//   i_bus_read_data(_valid)  read word and its one-cycle valid
module debug_burst_master #(
  parameter int ADDR_BYTES     = 2,
  parameter int DATA_BYTES     = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              i_com_data,
  input  logic                    i_com_strobe,
  input  logic                    i_com_tx_ready,
  output logic [7:0]              o_com_data,
  output logic                    o_com_strobe,
  output logic [8*ADDR_BYTES-1:0] o_bus_addr,
  output logic [8*DATA_BYTES-1:0] o_bus_write_data,
  output logic                    o_bus_write_enable,
  output logic                    o_bus_read_enable,
  input  logic                    i_bus_ready,
  input  logic [8*DATA_BYTES-1:0] i_bus_read_data,
  input  logic                    i_bus_read_data_valid
);

  localparam int AW = 8 * ADDR_BYTES;
  localparam int DW = 8 * DATA_BYTES;

  localparam logic [7:0] CH_W = 8'h57, CH_R = 8'h52, CH_B = 8'h42, CH_C = 8'h43;
  localparam logic [7:0] CH_K = 8'h4B, CH_Q = 8'h3F, CH_E = 8'h45;

  typedef enum logic [2:0] {S_IDLE, S_COUNT, S_ADDR, S_DATA, S_WRITE, S_READ, S_TX} state_t;

  state_t          state_reg, state_next;
  logic            cmd_read_reg;   // current command is R or C
  logic            resp_read_reg;  // TX is carrying read data (not a status char)
  logic [7:0]      remaining_reg;  // burst words still to do after the current one
  logic [2:0]      byte_cnt_reg;
  logic [15:0]     timer_reg;
  logic [AW-1:0]   addr_shift_reg;
  logic [DW-1:0]   data_shift_reg;
  logic [DW-1:0]   tx_shift_reg;   // next byte to send sits in the top byte
  logic [2:0]      tx_left_reg;

  logic [AW-1:0]   addr_shifted;
  logic [DW-1:0]   data_shifted;
  logic            is_single, is_burst, is_read_cmd;
  logic            addr_last, data_last, timed_out, burst_more, tx_last;

  // Status characters are left-aligned so they leave through the same
  // top-byte path as read data.
  function automatic logic [DW-1:0] char_word(input logic [7:0] c);
    return DW'(c) << (DW - 8);
  endfunction

  // Casting truncates the oldest byte, so this also works for 1-byte fields.
  assign addr_shifted = AW'({addr_shift_reg, i_com_data});
  assign data_shifted = DW'({data_shift_reg, i_com_data});

  assign is_single   = (i_com_data == CH_W) || (i_com_data == CH_R);
  assign is_burst    = (i_com_data == CH_B) || (i_com_data == CH_C);
  assign is_read_cmd = (i_com_data == CH_R) || (i_com_data == CH_C);
  assign addr_last   = (byte_cnt_reg == 3'(ADDR_BYTES - 1));
  assign data_last   = (byte_cnt_reg == 3'(DATA_BYTES - 1));
  assign timed_out   = (timer_reg == 16'(TIMEOUT_CYCLES - 1));
  assign burst_more  = (remaining_reg != 8'd0);
  assign tx_last     = (tx_left_reg == 3'd1);

  assign o_com_data         = tx_shift_reg[DW-1 -: 8];
  assign o_com_strobe       = (state_reg == S_TX) && i_com_tx_ready;
  assign o_bus_write_enable = (state_reg == S_WRITE);
  assign o_bus_read_enable  = (state_reg == S_READ);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:
        if (i_com_strobe) begin
          if (is_burst)       state_next = S_COUNT;
          else if (is_single) state_next = S_ADDR;
          else                state_next = S_TX;
        end
      S_COUNT: if (i_com_strobe) state_next = S_ADDR;
      S_ADDR:  if (i_com_strobe && addr_last) state_next = cmd_read_reg ? S_READ : S_DATA;
      S_DATA:  if (i_com_strobe && data_last) state_next = S_WRITE;
      S_WRITE:
        if (i_bus_ready)    state_next = burst_more ? S_DATA : S_TX;
        else if (timed_out) state_next = S_TX;
      S_READ:
        if (i_bus_read_data_valid || timed_out) state_next = S_TX;
      S_TX:
        if (i_com_tx_ready && tx_last)
          state_next = (resp_read_reg && burst_more) ? S_READ : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_read_reg     <= 1'b0;
      resp_read_reg    <= 1'b0;
      remaining_reg    <= '0;
      byte_cnt_reg     <= '0;
      timer_reg        <= '0;
      addr_shift_reg   <= '0;
      data_shift_reg   <= '0;
      tx_shift_reg     <= '0;
      tx_left_reg      <= '0;
      o_bus_addr       <= '0;
      o_bus_write_data <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          byte_cnt_reg <= '0;
          if (i_com_strobe) begin
            cmd_read_reg  <= is_read_cmd;
            remaining_reg <= '0;
            if (!(is_single || is_burst)) begin
              tx_shift_reg  <= char_word(CH_Q);
              tx_left_reg   <= 3'd1;
              resp_read_reg <= 1'b0;
            end
          end
        end
        S_COUNT: if (i_com_strobe) remaining_reg <= i_com_data;
        S_ADDR:
          if (i_com_strobe) begin
            addr_shift_reg <= addr_shifted;
            if (addr_last) begin
              o_bus_addr   <= addr_shifted;
              byte_cnt_reg <= '0;
              timer_reg    <= '0;
            end else begin
              byte_cnt_reg <= byte_cnt_reg + 3'd1;
            end
          end
        S_DATA:
          if (i_com_strobe) begin
            data_shift_reg <= data_shifted;
            if (data_last) begin
              o_bus_write_data <= data_shifted;
              byte_cnt_reg     <= '0;
              timer_reg        <= '0;
            end else begin
              byte_cnt_reg <= byte_cnt_reg + 3'd1;
            end
          end
        S_WRITE: begin
          // Ready wins over a timeout landing in the same cycle.
          if (i_bus_ready) begin
            if (burst_more) begin
              o_bus_addr    <= o_bus_addr + AW'(1);
              remaining_reg <= remaining_reg - 8'd1;
            end else begin
              tx_shift_reg  <= char_word(CH_K);
              tx_left_reg   <= 3'd1;
              resp_read_reg <= 1'b0;
            end
          end else if (timed_out) begin
            tx_shift_reg  <= char_word(CH_E);
            tx_left_reg   <= 3'd1;
            resp_read_reg <= 1'b0;
          end else begin
            timer_reg <= timer_reg + 16'd1;
          end
        end
        S_READ: begin
          if (i_bus_read_data_valid) begin
            tx_shift_reg  <= i_bus_read_data;
            tx_left_reg   <= 3'(DATA_BYTES);
            resp_read_reg <= 1'b1;
          end else if (timed_out) begin
            tx_shift_reg  <= char_word(CH_E);
            tx_left_reg   <= 3'd1;
            resp_read_reg <= 1'b0;
          end else begin
            timer_reg <= timer_reg + 16'd1;
          end
        end
        S_TX:
          if (i_com_tx_ready) begin
            tx_shift_reg <= tx_shift_reg << 8;
            tx_left_reg  <= tx_left_reg - 3'd1;
            // Last byte of a burst-read word: step to the next word.
            if (tx_last && resp_read_reg && burst_more) begin
              o_bus_addr    <= o_bus_addr + AW'(1);
              remaining_reg <= remaining_reg - 8'd1;
              timer_reg     <= '0;
            end
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_burst_master.sv
// Testbench for debug_burst_master (ADDR_BYTES=2, DATA_BYTES=2, TIMEOUT_CYCLES=8).
// Expected response bytes, bus writes, read addresses and enable run lengths
// are queued when a command is driven and compared as the DUT produces them.
module tb_debug_burst_master;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  i_com_data;
  logic        i_com_strobe;
  logic        i_com_tx_ready;
  logic [7:0]  o_com_data;
  logic        o_com_strobe;
  logic [15:0] o_bus_addr;
  logic [15:0] o_bus_write_data;
  logic        o_bus_write_enable;
  logic        o_bus_read_enable;
  logic        i_bus_ready;
  logic [15:0] i_bus_read_data;
  logic        i_bus_read_data_valid;

  always #5 clk = ~clk;

  debug_burst_master #(.ADDR_BYTES(2), .DATA_BYTES(2), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .i_com_data(i_com_data), .i_com_strobe(i_com_strobe), .i_com_tx_ready(i_com_tx_ready),
    .o_com_data(o_com_data), .o_com_strobe(o_com_strobe),
    .o_bus_addr(o_bus_addr), .o_bus_write_data(o_bus_write_data),
    .o_bus_write_enable(o_bus_write_enable), .o_bus_read_enable(o_bus_read_enable),
    .i_bus_ready(i_bus_ready), .i_bus_read_data(i_bus_read_data),
    .i_bus_read_data_valid(i_bus_read_data_valid)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0]  exp_tx[$];
  logic [31:0] exp_wr[$];
  logic [15:0] exp_rd_addr[$];
  int          exp_wlen[$];
  int          exp_rlen[$];
  logic [15:0] rd_q[$];

  int wr_delay = -1;
  int rd_delay = -1;
  int rx_count = 0;

  typedef struct {
    logic [7:0]  op;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          delay;      // cycles of enable before ready/valid, -1 = never
    logic [15:0] rdata;
    int          exp_len;    // expected enable high cycles (0 = no access)
    logic [7:0]  exp_b0;
    logic [7:0]  exp_b1;
    int          exp_n;      // number of response bytes
    bit          exp_write;  // a completed bus write is expected
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=done", name);
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // Called aligned (#1 after a rising edge); returns aligned.
  task automatic send_byte(input logic [7:0] b);
    i_com_data   = b;
    i_com_strobe = 1'b1;
    @(posedge clk);
    #1;
    i_com_strobe = 1'b0;
    i_com_data   = 8'h00;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 300; i++) begin
      if (exp_tx.size() == 0 && exp_wr.size() == 0 && exp_rd_addr.size() == 0 &&
          exp_wlen.size() == 0 && exp_rlen.size() == 0)
        break;
      @(negedge clk);
    end
    if (i == 300) begin
      fail_now("wait_idle");
      exp_tx.delete(); exp_wr.delete(); exp_rd_addr.delete();
      exp_wlen.delete(); exp_rlen.delete(); rd_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_wr(input int left);
    int i;
    for (i = 0; i < 100; i++) begin
      if (exp_wr.size() <= left) break;
      @(negedge clk);
    end
    if (i == 100) fail_now("wait_write");
    align();
  endtask

  // Bus responder: ready/valid after the programmed number of enable cycles;
  // random ready/valid noise while the matching enable is low.
  initial begin
    i_bus_ready = 1'b0;
    i_bus_read_data_valid = 1'b0;
    i_bus_read_data = '0;
    forever begin
      int wcnt, rcnt;
      @(posedge clk);
      #1;
      if (o_bus_write_enable) begin
        i_bus_ready = (wcnt == wr_delay);
        wcnt++;
      end else begin
        wcnt = 0;
        i_bus_ready = 1'($urandom_range(0, 1));
      end
      if (o_bus_read_enable) begin
        if (rcnt == rd_delay && rd_q.size() > 0) begin
          i_bus_read_data_valid = 1'b1;
          i_bus_read_data = rd_q.pop_front();
        end else begin
          i_bus_read_data_valid = 1'b0;
          i_bus_read_data = '0;
        end
        rcnt++;
      end else begin
        rcnt = 0;
        i_bus_read_data_valid = 1'($urandom_range(0, 1));
        i_bus_read_data = 16'($urandom);
      end
    end
  end

  // Monitor, sampled on the falling edge.
  initial begin
    int wrun, rrun;
    logic [7:0] eb;
    logic [31:0] ew;
    logic [15:0] ea;
    int el;
    wrun = 0;
    rrun = 0;
    forever begin
      @(negedge clk);
      if (o_com_strobe) begin
        rx_count++;
        check("tx_only_when_ready", 32'(i_com_tx_ready), 32'd1);
        if (exp_tx.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_tx_byte actual=%h required=none", o_com_data);
        end else begin
          eb = exp_tx.pop_front();
          check("tx_byte", 32'(o_com_data), 32'(eb));
        end
      end
      if (o_bus_write_enable && i_bus_ready) begin
        if (exp_wr.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_write actual=%h required=none", {o_bus_addr, o_bus_write_data});
        end else begin
          ew = exp_wr.pop_front();
          check("write_addr_data", {o_bus_addr, o_bus_write_data}, ew);
        end
      end
      if (o_bus_read_enable && i_bus_read_data_valid) begin
        if (exp_rd_addr.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_read actual=%h required=none", o_bus_addr);
        end else begin
          ea = exp_rd_addr.pop_front();
          check("read_addr", 32'(o_bus_addr), 32'(ea));
        end
      end
      if (rst) begin
        wrun = 0;
        rrun = 0;
      end else begin
        if (o_bus_write_enable) wrun++;
        else if (wrun > 0) begin
          el = (exp_wlen.size() > 0) ? exp_wlen.pop_front() : 0;
          check("write_enable_cycles", 32'(wrun), 32'(el));
          wrun = 0;
        end
        if (o_bus_read_enable) rrun++;
        else if (rrun > 0) begin
          el = (exp_rlen.size() > 0) ? exp_rlen.pop_front() : 0;
          check("read_enable_cycles", 32'(rrun), 32'(el));
          rrun = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_com_strobe"}, 32'(o_com_strobe), 32'd0);
    check({tag, "_com_data"}, 32'(o_com_data), 32'd0);
    check({tag, "_bus_addr"}, 32'(o_bus_addr), 32'd0);
    check({tag, "_bus_wdata"}, 32'(o_bus_write_data), 32'd0);
    check({tag, "_wr_en"}, 32'(o_bus_write_enable), 32'd0);
    check({tag, "_rd_en"}, 32'(o_bus_read_enable), 32'd0);
  endtask

  initial begin
    vec_t vecs[8];
    vecs[0] = '{8'h57, 16'h1234, 16'h00A5,  3, 16'h0000, 4, 8'h4B, 8'h00, 1, 1'b1};
    vecs[1] = '{8'h52, 16'h0010, 16'h0000,  2, 16'h005C, 3, 8'h00, 8'h5C, 2, 1'b0};
    vecs[2] = '{8'h52, 16'h0000, 16'h0000, -1, 16'h0000, 8, 8'h45, 8'h00, 1, 1'b0};
    vecs[3] = '{8'h57, 16'hABCD, 16'h1357,  0, 16'h0000, 1, 8'h4B, 8'h00, 1, 1'b1};
    vecs[4] = '{8'h41, 16'h0000, 16'h0000,  0, 16'h0000, 0, 8'h3F, 8'h00, 1, 1'b0};
    vecs[5] = '{8'h57, 16'h0001, 16'hCAFE,  7, 16'h0000, 8, 8'h4B, 8'h00, 1, 1'b1};
    vecs[6] = '{8'h52, 16'hFFFF, 16'h0000,  7, 16'hBEEF, 8, 8'hBE, 8'hEF, 2, 1'b0};
    vecs[7] = '{8'h57, 16'h0002, 16'h5555,  8, 16'h0000, 8, 8'h45, 8'h00, 1, 1'b0};

    rst = 1'b1;
    i_com_data = 8'h00;
    i_com_strobe = 1'b0;
    i_com_tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    align();

    for (int v = 0; v < 8; v++) begin
      vec_t t;
      t = vecs[v];
      exp_tx.push_back(t.exp_b0);
      if (t.exp_n == 2) exp_tx.push_back(t.exp_b1);
      case (t.op)
        8'h57: begin
          wr_delay = t.delay;
          if (t.exp_write) exp_wr.push_back({t.addr, t.wdata});
          exp_wlen.push_back(t.exp_len);
          send_byte(t.op); send_byte(t.addr[15:8]); send_byte(t.addr[7:0]);
          send_byte(t.wdata[15:8]); send_byte(t.wdata[7:0]);
        end
        8'h52: begin
          rd_delay = t.delay;
          if (t.delay >= 0) begin
            rd_q.push_back(t.rdata);
            exp_rd_addr.push_back(t.addr);
          end
          exp_rlen.push_back(t.exp_len);
          send_byte(t.op); send_byte(t.addr[15:8]); send_byte(t.addr[7:0]);
        end
        default: send_byte(t.op);
      endcase
      wait_idle();
    end

    // Burst write of 3 words across the address wrap, single "K".
    wr_delay = 0;
    exp_tx.push_back(8'h4B);
    exp_wr.push_back({16'hFFFE, 16'h0001});
    exp_wr.push_back({16'hFFFF, 16'h0002});
    exp_wr.push_back({16'h0000, 16'h0003});
    for (int k = 0; k < 3; k++) exp_wlen.push_back(1);
    send_byte(8'h42); send_byte(8'h02); send_byte(8'hFF); send_byte(8'hFE);
    for (int k = 0; k < 3; k++) begin
      send_byte(8'h00); send_byte(8'(k + 1));
      wait_wr(2 - k);
    end
    wait_idle();

    // Burst read of 2 words with the transmitter stalled mid-stream.
    rd_delay = 1;
    rd_q.push_back(16'hBEEF);
    rd_q.push_back(16'hCAFE);
    exp_rd_addr.push_back(16'h2000);
    exp_rd_addr.push_back(16'h2001);
    exp_rlen.push_back(2);
    exp_rlen.push_back(2);
    exp_tx.push_back(8'hBE); exp_tx.push_back(8'hEF);
    exp_tx.push_back(8'hCA); exp_tx.push_back(8'hFE);
    begin
      int rx0, i;
      rx0 = rx_count;
      send_byte(8'h43); send_byte(8'h01); send_byte(8'h20); send_byte(8'h00);
      for (i = 0; i < 100; i++) begin
        if (rx_count >= rx0 + 1) break;
        @(negedge clk);
      end
      if (i == 100) fail_now("wait_first_rx");
      align();
      i_com_tx_ready = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      i_com_tx_ready = 1'b1;
      wait_idle();
      check("burst_read_byte_count", 32'(rx_count - rx0), 32'd4);
    end

    // Reset in the middle of a burst write: no "K", then a normal write.
    wr_delay = 0;
    exp_wr.push_back({16'h0100, 16'h1111});
    exp_wlen.push_back(1);
    send_byte(8'h42); send_byte(8'h03); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h11);
    wait_wr(0);
    send_byte(8'h22);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("midburst_reset");
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("no_response_after_reset", 32'(exp_tx.size()), 32'd0);
    wr_delay = 1;
    exp_wr.push_back({16'h0002, 16'h3344});
    exp_wlen.push_back(2);
    exp_tx.push_back(8'h4B);
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h02); send_byte(8'h33); send_byte(8'h44);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
